fetch_decode_buffer: RTL and testbench

//  Elastic IF/ID stage directly downstream of the fetch cycle.
//  - Captures {PC, 32-bit instruction word} pairs from fetch into a small FIFO.
//  - Presents the head entry to decode with a valid/ready handshake, plus pre-sliced MIPS fields.
//  - Decouples fetch from decode stalls; supports a one-cycle flush for branches and jumps.

---
 rtl/fetch_decode_buffer_pkg.sv | 32 +++
 rtl/fetch_decode_buffer_if.sv | 39 +++
 rtl/fetch_decode_buffer_instr_field_decode.sv | 27 ++
 rtl/fetch_decode_buffer.sv | 107 ++++++++++
 tb/tb_fetch_decode_buffer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared constants and types for the IF/ID elastic buffer and the MIPS field decoder.
// Field positions follow the standard MIPS32 instruction layout.
package fetch_decode_buffer_pkg;

  localparam int FDB_DEPTH = 2;
  localparam int FDB_AW    = 1;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [5:0]  OPC_RTYPE  = 6'b000000;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID buffer.
// master = the environment (fetch + decode), slave = the buffer itself.
interface fetch_decode_buffer_if;

  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [31:0] out_imm_sext;
  logic        out_is_rtype;
  logic        out_is_nop;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr, out_opcode,
           out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm_sext,
           out_is_rtype, out_is_nop
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus4, out_instr, out_opcode,
           out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm_sext,
           out_is_rtype, out_is_nop
  );

endinterface

// File: rtl/fetch_decode_buffer_instr_field_decode.sv
// Purely combinational MIPS field slicer; reused by the decode and control units.
module instr_field_decode
  import fetch_decode_buffer_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic        is_rtype,
  output logic        is_nop
);

  assign opcode   = instr[OP_MSB:OP_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign rt       = instr[RT_MSB:RT_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign shamt    = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct    = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm_sext = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
  assign is_rtype = (opcode == OPC_RTYPE);
  assign is_nop   = (instr == NOP_WORD);

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID stage: small FIFO of {PC, instruction} pairs with a flush for redirects
// and pre-sliced MIPS fields on the head entry.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = FDB_DEPTH,
  parameter int AW    = FDB_AW
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  fetch_decode_buffer_if.slave  bus
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          push, pop, empty;
  fetch_entry_t  head;

  logic [5:0]    dec_opcode, dec_funct;
  logic [4:0]    dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [31:0]   dec_imm_sext;
  logic          dec_is_rtype, dec_is_nop;

  // in_ready depends on count only, so decode stalls never ripple combinationally into fetch.
  assign empty         = (count_q == '0);
  assign bus.in_ready  = (count_q != (AW+1)'(DEPTH));
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.in_pc, bus.in_instr};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  instr_field_decode u_decode (
    .instr    (head.instr),
    .opcode   (dec_opcode),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .rd       (dec_rd),
    .shamt    (dec_shamt),
    .funct    (dec_funct),
    .imm_sext (dec_imm_sext),
    .is_rtype (dec_is_rtype),
    .is_nop   (dec_is_nop)
  );

  // A zeroed head still decodes as an R-type NOP at PC+4=4, so those outputs need explicit gating.
  assign bus.out_pc       = head.pc;
  assign bus.out_instr    = head.instr;
  assign bus.out_pc_plus4 = empty ? '0 : head.pc + WORD_BYTES;
  assign bus.out_opcode   = dec_opcode;
  assign bus.out_rs       = dec_rs;
  assign bus.out_rt       = dec_rt;
  assign bus.out_rd       = dec_rd;
  assign bus.out_shamt    = dec_shamt;
  assign bus.out_funct    = dec_funct;
  assign bus.out_imm_sext = dec_imm_sext;
  assign bus.out_is_rtype = dec_is_rtype & !empty;
  assign bus.out_is_nop   = dec_is_nop & !empty;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of a 2-entry FIFO with flush.
module tb_fetch_decode_buffer;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic        is_rtype;
    logic        is_nop;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  fetch_decode_buffer_if bus();

  fetch_decode_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  entry_t model_q[$];
  int     vectors     = 0;
  int     miscompares = 0;
  outs_t  obs;
  outs_t  exp_o;

  function automatic outs_t observe();
    outs_t o;
    o.in_ready  = bus.in_ready;
    o.out_valid = bus.out_valid;
    o.pc        = bus.out_pc;
    o.pc4       = bus.out_pc_plus4;
    o.instr     = bus.out_instr;
    o.opcode    = bus.out_opcode;
    o.rs        = bus.out_rs;
    o.rt        = bus.out_rt;
    o.rd        = bus.out_rd;
    o.shamt     = bus.out_shamt;
    o.funct     = bus.out_funct;
    o.imm       = bus.out_imm_sext;
    o.is_rtype  = bus.out_is_rtype;
    o.is_nop    = bus.out_is_nop;
    return o;
  endfunction

  // Expected outputs from the model queue, using arithmetic rather than bit slicing.
  function automatic outs_t predict();
    outs_t       o;
    logic [31:0] w;
    logic [31:0] imm;
    o          = '0;
    o.in_ready = (model_q.size() < DEPTH);
    if (model_q.size() != 0) begin
      w           = model_q[0].instr;
      o.out_valid = 1'b1;
      o.pc        = model_q[0].pc;
      o.pc4       = model_q[0].pc + 32'd4;
      o.instr     = w;
      o.opcode    = 6'(w / 32'h0400_0000);
      o.rs        = 5'((w / 32'h0020_0000) % 32);
      o.rt        = 5'((w / 32'h0001_0000) % 32);
      o.rd        = 5'((w / 32'h0000_0800) % 32);
      o.shamt     = 5'((w / 32'h0000_0040) % 32);
      o.funct     = 6'(w % 64);
      imm         = w % 32'h0001_0000;
      if (imm >= 32'h0000_8000) imm = imm + 32'hFFFF_0000;
      o.imm       = imm;
      o.is_rtype  = (w < 32'h0400_0000);
      o.is_nop    = (w == 32'h0);
    end
    return o;
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input bit ordy, input bit fl, input bit r);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    flush         = fl;
    rst           = r;
  endtask

  // Advance the model by one clock using the currently driven inputs, then step the DUT.
  task automatic cycle();
    bit rdy;
    bit do_push;
    bit do_pop;
    rdy     = (model_q.size() < DEPTH);
    do_push = bus.in_valid && rdy;
    do_pop  = (model_q.size() != 0) && bus.out_ready;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({bus.in_pc, bus.in_instr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    cycle();
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, expected %h", obs, exp_o);
    end
    vectors++;
    if (obs !== outs_t'({1'b1, {($bits(outs_t)-1){1'b0}}})) begin
      miscompares++;
      $display("[TB] FAIL reset_all_zero: got %h, expected in_ready=1 and zeros", obs);
    end
  endtask

  task automatic test_pass_through();
    drive(1'b1, 32'h0, 32'h012A_4020, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o) begin
      miscompares++;
      $display("[TB] FAIL pass_model: got %h, expected %h", obs, exp_o);
    end
    vectors++;
    if ({obs.out_valid, obs.opcode, obs.rs, obs.rt, obs.rd, obs.funct, obs.is_rtype, obs.pc4} !==
        {1'b1, 6'd0, 5'd9, 5'd10, 5'd8, 6'h20, 1'b1, 32'd4}) begin
      miscompares++;
      $display("[TB] FAIL pass_fields: got v=%0b op=%h rs=%0d rt=%0d rd=%0d fn=%h rt=%0b pc4=%h",
               obs.out_valid, obs.opcode, obs.rs, obs.rt, obs.rd, obs.funct, obs.is_rtype, obs.pc4);
    end
    cycle();
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o) begin
      miscompares++;
      $display("[TB] FAIL pass_drain: got %h, expected %h", obs, exp_o);
    end
  endtask

  task automatic test_fill_stall();
    drive(1'b1, 32'h0, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h4, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h8, 32'hAAAA_0003, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_full_ready: got %b, expected 0", bus.in_ready);
    end
    cycle();
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o) begin
      miscompares++;
      $display("[TB] FAIL fill_stalled: got %h, expected %h", obs, exp_o);
    end
    drive(1'b1, 32'h8, 32'hAAAA_0003, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus.out_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL fill_head0: got %h, expected 00000000", bus.out_pc);
    end
    cycle();
    vectors++;
    if ({bus.out_pc, bus.in_ready} !== {32'h4, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL fill_head4: got pc=%h rdy=%b, expected pc=00000004 rdy=1",
               bus.out_pc, bus.in_ready);
    end
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o || obs.pc !== 32'h8) begin
      miscompares++;
      $display("[TB] FAIL fill_head8: got %h, expected %h", obs, exp_o);
    end
    cycle();
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o) begin
      miscompares++;
      $display("[TB] FAIL fill_drain: got %h, expected %h", obs, exp_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = 32'h0000_0100;
    drive(1'b1, base, $urandom, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, base + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b0);
      obs = observe(); exp_o = predict(); vectors++;
      if (obs !== exp_o || obs.pc !== base + 32'(4 * (i - 1)) || obs.in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_step%0d: got %h, expected %h", i, obs, exp_o);
      end
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0000_2000, $urandom, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_2004, $urandom, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_2008, $urandom, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      obs = observe(); exp_o = predict(); vectors++;
      if (obs !== exp_o || obs.out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_empty%0d: got %h, expected %h", i, obs, exp_o);
      end
      cycle();
    end
  endtask

  task automatic test_imm_nop();
    drive(1'b1, 32'h0000_3000, 32'h2008_FFFF, 1'b0, 1'b0, 1'b0);
    cycle();
    vectors++;
    if ({bus.out_imm_sext, bus.out_is_rtype} !== {32'hFFFF_FFFF, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL imm_sext: got imm=%h rtype=%b, expected imm=ffffffff rtype=0",
               bus.out_imm_sext, bus.out_is_rtype);
    end
    drive(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    obs = observe(); exp_o = predict(); vectors++;
    if (obs !== exp_o || {obs.is_nop, obs.pc4} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL nop_wrap: got %h, expected %h", obs, exp_o);
    end
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] instr;
    for (int i = 0; i < 400; i++) begin
      instr = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      drive(1'($urandom_range(0, 3) != 0), $urandom, instr, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
      obs = observe(); exp_o = predict(); vectors++;
      if (obs !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got %h, expected %h", i, obs, exp_o);
      end
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_back_to_back();
    test_flush();
    test_imm_nop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
